// File: rtl/exu_wb_arb.sv
// Write-back arbiter: merges the non-stallable MUL result stream with ALU results
// onto one register-file write port, buffering losing ALU results in an in-order FIFO.
module exu_wb_arb #(
  parameter int XLEN                = 64,
  parameter int REG_FILE_ADDR_WIDTH = 4,
  parameter int INSTR_LEN           = 64,
  parameter int DEPTH               = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alu_valid,
  input  logic [XLEN-1:0]                alu_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] alu_rd_addr,
  input  logic [XLEN-1:0]                alu_tag,
  input  logic [INSTR_LEN-1:0]           alu_instr,
  input  logic                           mul_valid,
  input  logic [XLEN-1:0]                mul_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] mul_rd_addr,
  input  logic [XLEN-1:0]                mul_tag,
  input  logic [INSTR_LEN-1:0]           mul_instr,
  output logic                           wb_valid,
  output logic [XLEN-1:0]                wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_addr,
  output logic [XLEN-1:0]                wb_tag,
  output logic [INSTR_LEN-1:0]           wb_instr,
  output logic                           freeze,
  output logic                           alu_pending,
  output logic                           overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0] FREEZE_LVL = CW'(DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0]                data;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]                tag;
    logic [INSTR_LEN-1:0]           instr;
  } entry_t;

  entry_t mem_q [DEPTH];

  entry_t        wb_q, wb_d;
  logic          wb_valid_q, wb_valid_d;
  logic          freeze_q, freeze_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  entry_t mul_e, alu_e;
  logic   fifo_empty, fifo_full, deq, bypass, enq, drop;

  assign mul_e = '{data: mul_data, rd: mul_rd_addr, tag: mul_tag, instr: mul_instr};
  assign alu_e = '{data: alu_data, rd: alu_rd_addr, tag: alu_tag, instr: alu_instr};

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_LVL);
  assign deq        = !mul_valid && !fifo_empty;
  assign bypass     = !mul_valid && fifo_empty && alu_valid;
  // When full, an enqueue is only possible if the head leaves in the same cycle.
  assign enq        = alu_valid && !bypass && (!fifo_full || deq);
  assign drop       = alu_valid && !bypass && fifo_full && !deq;

  always_comb begin
    wb_valid_d = 1'b0;
    wb_d       = wb_q;
    if (mul_valid) begin
      wb_valid_d = 1'b1;
      wb_d       = mul_e;
    end else if (deq) begin
      wb_valid_d = 1'b1;
      wb_d       = mem_q[rd_ptr_q];
    end else if (bypass) begin
      wb_valid_d = 1'b1;
      wb_d       = alu_e;
    end
    count_d    = count_q + CW'(enq) - CW'(deq);
    wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    freeze_d   = (count_d >= FREEZE_LVL);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      freeze_q   <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      freeze_q   <= freeze_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= alu_e;
  end

  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_q.data;
  assign wb_rd_addr   = wb_q.rd;
  assign wb_tag       = wb_q.tag;
  assign wb_instr     = wb_q.instr;
  assign freeze       = freeze_q;
  assign overflow_err = overflow_q;
  assign alu_pending  = (count_q != '0);

endmodule

// File: tb/tb_exu_wb_arb.sv
// Self-checking bench for exu_wb_arb: directed vector table, a reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_exu_wb_arb;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  rd;
    logic [63:0] tag;
    logic [63:0] instr;
  } ent_t;

  typedef struct {
    bit          mv;
    logic [63:0] md;
    logic [3:0]  mrd;
    bit          av;
    logic [63:0] ad;
    logic [3:0]  ard;
    bit          e_v;
    logic [63:0] e_d;
    logic [3:0]  e_rd;
    bit          e_pend;
    bit          e_frz;
    bit          e_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mul_valid = 1'b0;
  logic [63:0] alu_data = '0, alu_tag = '0, alu_instr = '0;
  logic [63:0] mul_data = '0, mul_tag = '0, mul_instr = '0;
  logic [3:0]  alu_rd_addr = '0, mul_rd_addr = '0;
  logic        wb_valid, freeze, alu_pending, overflow_err;
  logic [63:0] wb_data, wb_tag, wb_instr;
  logic [3:0]  wb_rd_addr;

  int n_cmp = 0;
  int n_bad = 0;

  exu_wb_arb #(.XLEN(64), .REG_FILE_ADDR_WIDTH(4), .INSTR_LEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_data(alu_data), .alu_rd_addr(alu_rd_addr),
    .alu_tag(alu_tag), .alu_instr(alu_instr),
    .mul_valid(mul_valid), .mul_data(mul_data), .mul_rd_addr(mul_rd_addr),
    .mul_tag(mul_tag), .mul_instr(mul_instr),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_tag(wb_tag), .wb_instr(wb_instr),
    .freeze(freeze), .alu_pending(alu_pending), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] tag_of(input logic [63:0] d);
    return d ^ 64'hA5A5_0000_0000_5A5A;
  endfunction

  function automatic logic [63:0] instr_of(input logic [63:0] d);
    return {d[31:0], ~d[31:0]};
  endfunction

  function automatic ent_t mk(input logic [63:0] d, input logic [3:0] rd);
    return '{data: d, rd: rd, tag: tag_of(d), instr: instr_of(d)};
  endfunction

  function automatic vec_t v(input bit mv, input logic [63:0] md, input logic [3:0] mrd,
                             input bit av, input logic [63:0] ad, input logic [3:0] ard,
                             input bit ev, input logic [63:0] ed, input logic [3:0] erd,
                             input bit ep, input bit ef, input bit eo);
    return '{mv, md, mrd, av, ad, ard, ev, ed, erd, ep, ef, eo};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input bit ev, input ent_t ee,
                         input bit ep, input bit ef, input bit eo);
    chk({nm, ".wb_valid"}, 64'(wb_valid), 64'(ev));
    chk({nm, ".wb_data"}, wb_data, ee.data);
    chk({nm, ".wb_rd"}, 64'(wb_rd_addr), 64'(ee.rd));
    chk({nm, ".wb_tag"}, wb_tag, ee.tag);
    chk({nm, ".wb_instr"}, wb_instr, ee.instr);
    chk({nm, ".pending"}, 64'(alu_pending), 64'(ep));
    chk({nm, ".freeze"}, 64'(freeze), 64'(ef));
    chk({nm, ".ovf"}, 64'(overflow_err), 64'(eo));
  endtask

  task automatic drive(input bit mv, input ent_t me, input bit av, input ent_t ae);
    mul_valid = mv; mul_data = me.data; mul_rd_addr = me.rd; mul_tag = me.tag; mul_instr = me.instr;
    alu_valid = av; alu_data = ae.data; alu_rd_addr = ae.rd; alu_tag = ae.tag; alu_instr = ae.instr;
  endtask

  // Reference model: a bounded queue of waiting ALU results plus the last write-back.
  ent_t q[$];
  bit   m_v, m_frz, m_ovf;
  ent_t m_e;

  task automatic model_reset();
    q.delete();
    m_v = 0; m_frz = 0; m_ovf = 0; m_e = '0;
  endtask

  task automatic model_step(input bit mv, input ent_t me, input bit av, input ent_t ae);
    if (mv) begin
      m_v = 1; m_e = me;
      if (av) begin
        if (q.size() < DEPTH) q.push_back(ae);
        else m_ovf = 1;
      end
    end else if (q.size() > 0) begin
      m_v = 1; m_e = q.pop_front();
      if (av) q.push_back(ae);
    end else if (av) begin
      m_v = 1; m_e = ae;
    end else begin
      m_v = 0;
    end
    m_frz = (q.size() >= DEPTH - 1);
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = v(0, 0, 0,     1, 64'h11, 3,  1, 64'h11, 3,  0, 0, 0);
    vt[1]  = v(0, 0, 0,     0, 0, 0,       0, 64'h11, 3,  0, 0, 0);
    vt[2]  = v(1, 64'hAA, 1, 1, 64'hBB, 2, 1, 64'hAA, 1,  1, 0, 0);
    vt[3]  = v(0, 0, 0,     0, 0, 0,       1, 64'hBB, 2,  0, 0, 0);
    vt[4]  = v(1, 64'h21, 5, 1, 64'h1, 6,  1, 64'h21, 5,  1, 0, 0);
    vt[5]  = v(1, 64'h22, 5, 1, 64'h2, 7,  1, 64'h22, 5,  1, 0, 0);
    vt[6]  = v(1, 64'h23, 5, 1, 64'h3, 8,  1, 64'h23, 5,  1, 1, 0);
    vt[7]  = v(1, 64'h24, 5, 1, 64'h4, 9,  1, 64'h24, 5,  1, 1, 0);
    vt[8]  = v(1, 64'h25, 5, 1, 64'h5, 10, 1, 64'h25, 5,  1, 1, 1);
    vt[9]  = v(0, 0, 0,     0, 0, 0,       1, 64'h1, 6,   1, 1, 1);
    vt[10] = v(0, 0, 0,     0, 0, 0,       1, 64'h2, 7,   1, 0, 1);
    vt[11] = v(0, 0, 0,     0, 0, 0,       1, 64'h3, 8,   1, 0, 1);
    vt[12] = v(0, 0, 0,     0, 0, 0,       1, 64'h4, 9,   0, 0, 1);
    vt[13] = v(0, 0, 0,     0, 0, 0,       0, 64'h4, 9,   0, 0, 1);

    #1;
    chk_all("reset", 0, '0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].mv, mk(vt[i].md, vt[i].mrd), vt[i].av, mk(vt[i].ad, vt[i].ard));
      @(posedge clk); #1;
      $display("vec %0d: mul=%0b alu=%0b -> wb_valid=%0b data=%h rd=%0d pend=%0b frz=%0b ovf=%0b",
               i, vt[i].mv, vt[i].av, wb_valid, wb_data, wb_rd_addr, alu_pending, freeze, overflow_err);
      chk_all($sformatf("vec%0d", i), vt[i].e_v, mk(vt[i].e_d, vt[i].e_rd),
              vt[i].e_pend, vt[i].e_frz, vt[i].e_ovf);
    end

    // Buffer three ALU results behind MUL, then reset asynchronously between edges.
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(64'h31 + 64'(i), 1), 1, mk(64'h41 + 64'(i), 2));
      @(posedge clk); #1;
    end
    $display("pre-reset: pend=%0b frz=%0b ovf=%0b", alu_pending, freeze, overflow_err);
    chk("prerst.pending", 64'(alu_pending), 64'd1);
    chk("prerst.freeze", 64'(freeze), 64'd1);
    drive(0, '0, 0, '0);
    #2 rst = 1'b1;
    #1;
    $display("in reset: wb_valid=%0b data=%h pend=%0b frz=%0b ovf=%0b",
             wb_valid, wb_data, alu_pending, freeze, overflow_err);
    chk_all("async_rst", 0, '0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    $display("post-reset: wb_valid=%0b pend=%0b frz=%0b", wb_valid, alu_pending, freeze);
    chk_all("post_rst", 0, '0, 0, 0, 0);

    // Randomized traffic; the model starts from the post-reset state (one idle cycle matches).
    model_reset();
    for (int i = 0; i < 600; i++) begin
      bit   mv, av;
      ent_t me, ae;
      if (i % 200 == 199) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
      end
      mv = ($urandom_range(0, 99) < 55);
      av = ($urandom_range(0, 99) < 65);
      me = mk({$urandom, $urandom}, 4'($urandom_range(0, 15)));
      ae = mk({$urandom, $urandom}, 4'($urandom_range(0, 15)));
      drive(mv, me, av, ae);
      model_step(mv, me, av, ae);
      @(posedge clk); #1;
      $display("rnd %0d: mul=%0b alu=%0b -> wb_valid=%0b data=%h qsize=%0d frz=%0b ovf=%0b",
               i, mv, av, wb_valid, wb_data, q.size(), freeze, overflow_err);
      chk_all($sformatf("rnd%0d", i), m_v, m_e, q.size() != 0, m_frz, m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exu_wb_arb.md
# exu_wb_arb

Write-back arbiter directly downstream of the multiply unit and the single-cycle ALU. It merges the MUL result stream, which arrives 3 cycles after issue and cannot stall, with the ALU result stream onto the single register-file write port. The MUL path always has priority. ALU results that lose arbitration are held in a small in-order FIFO, and the block raises `freeze` to the issue stage before that FIFO can overflow.

## Interface
Parameters:
- `XLEN`, default 64: data width.
- `REG_FILE_ADDR_WIDTH`, default 4: register address width.
- `INSTR_LEN`, default 64: instruction width.
- `DEPTH`, default 4: ALU holding FIFO entries. Must be ≥2 and a power of 2.

Ports:
- Clocking and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `alu_valid`  in  1  ALU result valid this cycle.
- `alu_data`  in  XLEN  ALU result.
- `alu_rd_addr`  in  REG_FILE_ADDR_WIDTH  ALU destination register.
- `alu_tag`  in  XLEN  ALU instruction tag.
- `alu_instr`  in  INSTR_LEN  ALU instruction.
- `mul_valid`  in  1  MUL write enable (the MUL out_rd_wr_en).
- `mul_data`  in  XLEN  MUL result.
- `mul_rd_addr`  in  REG_FILE_ADDR_WIDTH  MUL destination register.
- `mul_tag`  in  XLEN  MUL instruction tag.
- `mul_instr`  in  INSTR_LEN  MUL instruction.
- `wb_valid`  out  1  register-file write enable.
- `wb_data`  out  XLEN  write data.
- `wb_rd_addr`  out  REG_FILE_ADDR_WIDTH  write address.
- `wb_tag`  out  XLEN  retired instruction tag.
- `wb_instr`  out  INSTR_LEN  retired instruction.
- `freeze`  out  1  stall request to issue; registered.
- `alu_pending`  out  1  FIFO non-empty; combinational from count.
- `overflow_err`  out  1  sticky: an ALU result was dropped.

## Operation
- State:
  - FIFO of `DEPTH` entries, each {data, rd_addr, tag, instr}.
  - Read and write pointers of log2(DEPTH) bits; they wrap modulo DEPTH.
  - Count register of log2(DEPTH)+1 bits.
- Per-cycle selection, in priority order:
  1. `mul_valid`=1: MUL fields are selected for write-back.
  2. Otherwise, if the FIFO is non-empty: the FIFO head is selected and dequeued.
  3. Otherwise, if `alu_valid`=1: the ALU fields are selected directly (bypass, no enqueue).
  4. Otherwise: nothing is selected, and `wb_valid` is 0 next cycle.
- Enqueue rule: an incoming ALU result is enqueued when `alu_valid`=1 and it is not bypassed. This happens when `mul_valid`=1 or the FIFO is non-empty.
- Ordering: ALU results retire strictly in arrival order. An ALU result never overtakes an older buffered ALU result.
- Cross-source ordering and hazards between MUL and ALU destinations are the issue stage's responsibility, via `mul_busy`. This block does not reorder or compare addresses.
- Simultaneous enqueue and dequeue:
  - Allowed, including when the FIFO is full (the head leaves and the new entry takes its slot).
  - Count is unchanged.
- Overflow: if `alu_valid`=1, the FIFO is full, no dequeue occurs and the result is not bypassed:
  - The result is dropped.
  - `overflow_err` sets and stays set until reset.
  - FIFO contents and pointers are unchanged.
- Freeze: `freeze` is registered next cycle as (next_count ≥ DEPTH-1). This reserves one slot for an ALU result already in flight in the cycle `freeze` rises.
- `alu_pending` = (count ≠ 0).

## Timing
- Reset values (asynchronous, immediate on `rst`=1), all zero:
  - `wb_valid`, `wb_data`, `wb_rd_addr`, `wb_tag`, `wb_instr`
  - `freeze`, `overflow_err`
  - count, both pointers
  - `alu_pending` is therefore 0.
- Reset mid-operation discards all buffered entries. No write-back occurs in the first cycle after `rst` deasserts.
- Latency:
  - MUL input to `wb_*`: 1 cycle.
  - Bypassed ALU input to `wb_*`: 1 cycle.
  - Buffered ALU input: 1 cycle after it reaches the FIFO head and MUL is idle.
- Throughput: one write-back per cycle. Back-to-back MUL results starve the FIFO for as long as they last.
- `freeze` falls the cycle after next_count drops below DEPTH-1.
- `wb_*` are all registered. Data fields hold their last value when `wb_valid`=0.

## Test plan
- Reset, then `alu_valid` for one cycle with data=0x11 and rd=3:
  - Next cycle: `wb_valid`=1, `wb_data`=0x11, `wb_rd_addr`=3.
  - `alu_pending` stays 0 throughout.
- `mul_valid` and `alu_valid` in the same cycle (MUL data=0xAA, rd=1; ALU data=0xBB, rd=2):
  - Cycle+1: write-back of 0xAA to rd 1.
  - Cycle+2: write-back of 0xBB to rd 2.
  - `alu_pending` is 1 during cycle+1 only.
- `mul_valid` held for 4 cycles while ALU results 1, 2, 3, 4 arrive, with DEPTH=4:
  - `freeze` is 1 from the cycle after the 3rd enqueue.
  - The 4th ALU result still fits.
  - After MUL ends, the ALU results retire in order 1, 2, 3, 4.
  - `overflow_err` stays 0.
- Same stimulus as above plus a 5th ALU result while full:
  - The 5th result is dropped and `overflow_err`=1 (sticky).
  - Retired sequence is 1, 2, 3, 4 only.
- `rst` asserted with 3 buffered entries:
  - Outputs go to zero asynchronously.
  - After deassert: no write-back occurs, `alu_pending`=0, `freeze`=0.
